// File: rtl/delay_prog_nch.sv
// delay_prog_nch
//   CH independent two-phase request channels. A level change on inR[i] is
//   accepted when the channel is idle, and is reflected on outR[i] after a
//   runtime-programmable number of clock cycles sampled at acceptance.
//   A level change seen while the channel is busy sets a sticky ovf flag.
//   The changed level is then accepted at the first idle edge if it still
//   differs from the last accepted level.
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   inR      [CH]     two-phase request inputs (synchronous to clk)
//   dly      [CH*DW]  per-channel delay, channel i uses dly[i*DW +: DW]
//   clr_ovf  [CH]     per-channel clear of ovf (a set on the same edge wins)
//   outR     [CH]     delayed two-phase request outputs (registered)
//   busy     [CH]     channel holds an accepted, not yet emitted transition
//   ovf      [CH]     sticky overrun flag
module delay_prog_nch #(
  parameter int CH = 4,
  parameter int DW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    inR,
  input  logic [CH*DW-1:0] dly,
  input  logic [CH-1:0]    clr_ovf,
  output logic [CH-1:0]    outR,
  output logic [CH-1:0]    busy,
  output logic [CH-1:0]    ovf
);

  logic [CH-1:0] lvl_q, lvl_d;     // last accepted inR level per channel
  logic [CH-1:0] outr_q, outr_d;
  logic [CH-1:0] busy_q, busy_d;
  logic [CH-1:0] ovf_q, ovf_d;
  logic [DW-1:0] cnt_q [CH];
  logic [DW-1:0] cnt_d [CH];

  always_comb begin
    lvl_d  = lvl_q;
    outr_d = outr_q;
    busy_d = busy_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    for (int i = 0; i < CH; i++) begin
      if (busy_q[i]) begin
        // The completion edge is still a busy edge: no acceptance here.
        if (cnt_q[i] == '0) begin
          outr_d[i] = lvl_q[i];
          busy_d[i] = 1'b0;
        end else begin
          cnt_d[i] = cnt_q[i] - DW'(1);
        end
      end else if (inR[i] != lvl_q[i]) begin
        lvl_d[i] = inR[i];
        if (dly[i*DW +: DW] == '0) begin
          outr_d[i] = inR[i];
        end else begin
          // Loaded with D-1 so the countdown ends at zero without wrapping.
          cnt_d[i]  = dly[i*DW +: DW] - DW'(1);
          busy_d[i] = 1'b1;
        end
      end

      // Set has priority over clear.
      if (busy_q[i] && (inR[i] != lvl_q[i])) begin
        ovf_d[i] = 1'b1;
      end else if (clr_ovf[i]) begin
        ovf_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q  <= '0;
      outr_q <= '0;
      busy_q <= '0;
      ovf_q  <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      lvl_q  <= lvl_d;
      outr_q <= outr_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign outR = outr_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_delay_prog_nch.sv
// Testbench for delay_prog_nch: directed scenarios followed by random
// stimulus. A timestamp-based reference model predicts, for every accepted
// event, the edge at which outR must show it; a monitor applies those
// predictions and compares outR, busy and ovf every cycle.
module tb_delay_prog_nch;
  localparam int CH = 4;
  localparam int DW = 5;
  localparam int DMAX = (1 << DW) - 1;

  logic             clk;
  logic             rst;
  logic [CH-1:0]    inR;
  logic [CH*DW-1:0] dly;
  logic [CH-1:0]    clr_ovf;
  logic [CH-1:0]    outR;
  logic [CH-1:0]    busy;
  logic [CH-1:0]    ovf;

  delay_prog_nch #(.CH(CH), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .inR     (inR),
    .dly     (dly),
    .clr_ovf (clr_ovf),
    .outR    (outR),
    .busy    (busy),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   e;   // edge index at which outR must take the value
    int   ch;
    logic v;
    int   g;   // reset generation the event belongs to
  } ev_t;

  ev_t sb[$];

  int checks = 0;
  int fails  = 0;

  // Reference model state, expressed as absolute edge timestamps.
  int            n = 0;
  int            gen = 0;
  int            acc_e [CH];
  int            done_e[CH];
  logic [CH-1:0] m_lvl;
  logic [CH-1:0] exp_busy;
  logic [CH-1:0] exp_ovf;

  initial begin
    for (int i = 0; i < CH; i++) begin
      acc_e[i]  = -1;
      done_e[i] = -1;
    end
    m_lvl    = '0;
    exp_busy = '0;
    exp_ovf  = '0;
  end

  always @(posedge clk) begin
    int d;
    bit bsy;
    n = n + 1;
    if (rst) begin
      gen = gen + 1;
      m_lvl    = '0;
      exp_busy = '0;
      exp_ovf  = '0;
      for (int i = 0; i < CH; i++) begin
        acc_e[i]  = -1;
        done_e[i] = -1;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        // Busy at this edge: accepted earlier and not yet past completion.
        bsy = (acc_e[i] < n) && (n <= done_e[i]);
        if (bsy && (inR[i] != m_lvl[i])) exp_ovf[i] = 1'b1;
        else if (clr_ovf[i]) exp_ovf[i] = 1'b0;
        if ((n > done_e[i]) && (inR[i] != m_lvl[i])) begin
          m_lvl[i]  = inR[i];
          d         = int'(dly[i*DW +: DW]);
          acc_e[i]  = n;
          done_e[i] = n + d;
          sb.push_back('{e: n + d, ch: i, v: inR[i], g: gen});
        end
        exp_busy[i] = (acc_e[i] <= n) && (n < done_e[i]);
      end
    end
  end

  // Monitor: applies matured predictions and compares away from the edge.
  logic [CH-1:0] exp_out = '0;
  int            last_gen = 0;

  always @(negedge clk) begin
    if (gen != last_gen) begin
      exp_out  = '0;
      last_gen = gen;
    end
    for (int k = 0; k < sb.size(); ) begin
      if (sb[k].g != gen) begin
        sb.delete(k);
      end else if (sb[k].e <= n) begin
        exp_out[sb[k].ch] = sb[k].v;
        sb.delete(k);
      end else begin
        k++;
      end
    end
    checks++;
    if (outR !== exp_out) begin
      fails++;
      $display("FAIL outR edge=%0d actual=%h required=%h", n, outR, exp_out);
    end
    checks++;
    if (busy !== exp_busy) begin
      fails++;
      $display("FAIL busy edge=%0d actual=%h required=%h", n, busy, exp_busy);
    end
    checks++;
    if (ovf !== exp_ovf) begin
      fails++;
      $display("FAIL ovf edge=%0d actual=%h required=%h", n, ovf, exp_ovf);
    end
  end

  task automatic tick(input int c);
    for (int k = 0; k < c; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_dly(input int ch, input int v);
    dly[ch*DW +: DW] = DW'(v);
  endtask

  initial begin
    int pend;
    int r;
    rst     = 1'b1;
    inR     = '0;
    dly     = '0;
    clr_ovf = '0;

    // Reset with inputs active; all channels accept at the first free edge.
    inR = 4'hF;
    for (int i = 0; i < CH; i++) set_dly(i, 3);
    tick(2);
    rst = 1'b0;
    tick(6);
    inR = 4'h0;
    tick(6);

    // Single channel delay of 5.
    set_dly(0, 5);
    inR[0] = 1'b1;
    tick(8);

    // Zero delay follows on the same edge.
    set_dly(2, 0);
    inR[2] = ~inR[2];
    tick(1);
    inR[2] = ~inR[2];
    tick(3);

    // Overrun with a queued second event, then clear the flag.
    set_dly(1, 6);
    inR[1] = ~inR[1];
    tick(2);
    inR[1] = ~inR[1];
    tick(16);
    clr_ovf[1] = 1'b1;
    tick(1);
    clr_ovf[1] = 1'b0;
    tick(2);

    // Double toggle while busy nets to a single output event.
    set_dly(3, 4);
    inR[3] = ~inR[3];
    tick(1);
    inR[3] = ~inR[3];
    tick(1);
    inR[3] = ~inR[3];
    tick(1);
    inR[3] = ~inR[3];
    tick(8);
    clr_ovf = '1;
    tick(1);
    clr_ovf = '0;

    // Maximum delay; a later dly change must not affect the pending event.
    set_dly(0, DMAX);
    inR[0] = ~inR[0];
    tick(1);
    set_dly(0, 7);
    tick(36);

    // Reset in the middle of a maximum-length delay.
    set_dly(0, DMAX);
    inR[0] = ~inR[0];
    tick(10);
    rst = 1'b1;
    inR = '0;
    tick(2);
    rst = 1'b0;
    tick(40);

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(7) == 0) inR[i] = ~inR[i];
        if ($urandom_range(19) == 0) begin
          r = int'($urandom_range(4));
          case (r)
            0: set_dly(i, 0);
            1: set_dly(i, 1);
            2: set_dly(i, 2);
            3: set_dly(i, DMAX);
            default: set_dly(i, int'($urandom_range(DMAX)));
          endcase
        end
        clr_ovf[i] = ($urandom_range(9) == 0);
      end
      rst = ($urandom_range(499) == 0);
      tick(1);
    end
    rst     = 1'b0;
    clr_ovf = '0;
    tick(80);

    // Every prediction of the current generation must have been emitted.
    pend = 0;
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].g == gen) pend++;
    end
    checks++;
    if (pend != 0) begin
      fails++;
      $display("FAIL drain actual=%0d pending events required=0", pend);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
